// File: rtl/deal_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : deal_arbiter
// Brief    : Round-robin sharing of one card source between player and dealer,
//            with shoe-count tracking and shuffle reload.
// Revision : 1.0 - initial release
// ============================================================================
module deal_arbiter #(
    parameter int CARD_W    = 8,
    parameter int SRC_LAT   = 2,
    parameter int DECK_SIZE = 52
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              p_req_i,
    input  logic              d_req_i,
    output logic              p_ack_o,
    output logic              d_ack_o,
    output logic [CARD_W-1:0] card_o,
    output logic              request_card_o,
    input  logic [CARD_W-1:0] card_to_send_i,
    input  logic              shuffle_i,
    output logic [5:0]        cards_left_o,
    output logic              deck_empty_o,
    output logic              busy_o
);

    localparam logic [1:0] c_st_idle    = 2'd0;
    localparam logic [1:0] c_st_issue   = 2'd1;
    localparam logic [1:0] c_st_wait    = 2'd2;
    localparam logic [1:0] c_st_deliver = 2'd3;

    localparam logic c_side_player = 1'b0;
    localparam logic c_side_dealer = 1'b1;

    localparam logic [3:0] c_wait_load = 4'(SRC_LAT - 1);
    localparam logic [5:0] c_deck_full = 6'(DECK_SIZE);

    logic [1:0]        r_state;
    logic [1:0]        w_next_state;
    logic              r_grant;
    logic              r_last_grant;
    logic              r_shuffle_pend;
    logic [3:0]        r_wait_cnt;
    logic [CARD_W-1:0] r_card;
    logic [5:0]        r_cards_left;

    logic w_shuffle_now;
    logic w_grant_en;
    logic w_grant_side;
    logic w_deck_empty;
    logic w_request_card;
    logic w_p_ack;
    logic w_d_ack;
    logic w_busy;

    assign w_deck_empty = (r_cards_left == 6'd0);

    // A shuffle (live or deferred) owns the IDLE cycle, so no grant coincides with a reload.
    always_comb begin
        w_shuffle_now = (r_state == c_st_idle) && (shuffle_i || r_shuffle_pend);
        w_grant_en    = 1'b0;
        w_grant_side  = r_grant;
        if ((r_state == c_st_idle) && !w_shuffle_now && !w_deck_empty) begin
            case ({p_req_i, d_req_i})
                2'b10: begin
                    w_grant_en   = 1'b1;
                    w_grant_side = c_side_player;
                end
                2'b01: begin
                    w_grant_en   = 1'b1;
                    w_grant_side = c_side_dealer;
                end
                2'b11: begin
                    w_grant_en   = 1'b1;
                    w_grant_side = ~r_last_grant;
                end
                default: begin
                    w_grant_en   = 1'b0;
                    w_grant_side = r_grant;
                end
            endcase
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state <= c_st_idle;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_st_idle:    w_next_state = w_grant_en ? c_st_issue : c_st_idle;
            c_st_issue:   w_next_state = c_st_wait;
            c_st_wait:    w_next_state = (r_wait_cnt == 4'd0) ? c_st_deliver : c_st_wait;
            c_st_deliver: w_next_state = c_st_idle;
            default:      w_next_state = c_st_idle;
        endcase
    end

    always_comb begin
        w_request_card = (r_state == c_st_issue);
        w_p_ack        = (r_state == c_st_deliver) && (r_grant == c_side_player);
        w_d_ack        = (r_state == c_st_deliver) && (r_grant == c_side_dealer);
        w_busy         = (r_state != c_st_idle);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_grant        <= c_side_player;
            r_last_grant   <= c_side_dealer;
            r_shuffle_pend <= 1'b0;
            r_wait_cnt     <= 4'd0;
            r_card         <= '0;
            r_cards_left   <= c_deck_full;
        end else begin
            if (w_grant_en) begin
                r_grant      <= w_grant_side;
                r_last_grant <= w_grant_side;
            end

            if (r_state == c_st_issue) begin
                r_wait_cnt <= c_wait_load;
            end else if ((r_state == c_st_wait) && (r_wait_cnt != 4'd0)) begin
                r_wait_cnt <= r_wait_cnt - 4'd1;
            end

            if ((r_state == c_st_wait) && (r_wait_cnt == 4'd0)) begin
                r_card <= card_to_send_i;
            end

            // Mid-transaction shuffles are deferred so DELIVER's decrement lands first.
            if (w_shuffle_now) begin
                r_shuffle_pend <= 1'b0;
            end else if ((r_state != c_st_idle) && shuffle_i) begin
                r_shuffle_pend <= 1'b1;
            end

            if (w_shuffle_now) begin
                r_cards_left <= c_deck_full;
            end else if ((r_state == c_st_deliver) && !w_deck_empty) begin
                r_cards_left <= r_cards_left - 6'd1;
            end
        end
    end

    assign p_ack_o        = w_p_ack;
    assign d_ack_o        = w_d_ack;
    assign card_o         = r_card;
    assign request_card_o = w_request_card;
    assign cards_left_o   = r_cards_left;
    assign deck_empty_o   = w_deck_empty;
    assign busy_o         = w_busy;

endmodule
`default_nettype wire
